// File: rtl/write_back_stage.sv
// Write-back stage: picks the write-back source, aligns/extends load data, stalls for late
// loads (abandoning them after TIMEOUT cycles) and writes the register file one cycle later.
module write_back_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_ip,
    input  logic [1:0]       wb_sel_ip,
    input  logic [4:0]       rd_addr_ip,
    input  logic [31:0]      alu_result_ip,
    input  logic [31:0]      pc_addr_ip,
    input  logic [31:0]      uimmd_ip,
    input  logic [2:0]       lsu_op_ip,
    input  logic [1:0]       byte_off_ip,
    input  logic [31:0]      load_data_ip,
    input  logic             load_valid_ip,
    output logic             stall_op,
    output logic             rf_we_op,
    output logic [4:0]       rf_waddr_op,
    output logic [31:0]      rf_wdata_op,
    output logic             misalign_op,
    output logic             timeout_op,
    output logic [CNT_W-1:0] retired_op
);

    localparam logic [2:0] LSU_LB  = 3'd0;
    localparam logic [2:0] LSU_LH  = 3'd1;
    localparam logic [2:0] LSU_LBU = 3'd4;
    localparam logic [2:0] LSU_LHU = 3'd5;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;
    localparam logic [1:0] SEL_UIMM = 2'd3;

    localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_value;
    logic [31:0] wb_value;
    logic        aligned;
    logic        is_load;
    logic        enter_wait;
    logic        wait_expired;
    logic        complete_now;
    logic        misalign_now;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        ld_byte    = load_data_ip[{byte_off_ip, 3'b000} +: 8];
        ld_half    = load_data_ip[{byte_off_ip[1], 4'b0000} +: 16];
        load_value = load_data_ip;
        aligned    = (byte_off_ip == 2'd0);

        // Unlisted encodings fall through to the word-load defaults above.
        case (lsu_op_ip)
            LSU_LB:  begin load_value = {{24{ld_byte[7]}}, ld_byte}; aligned = 1'b1; end
            LSU_LBU: begin load_value = {24'd0, ld_byte};            aligned = 1'b1; end
            LSU_LH:  begin load_value = {{16{ld_half[15]}}, ld_half}; aligned = !byte_off_ip[0]; end
            LSU_LHU: begin load_value = {16'd0, ld_half};            aligned = !byte_off_ip[0]; end
            default: ;
        endcase

        wb_value = alu_result_ip;
        case (wb_sel_ip)
            SEL_ALU:  wb_value = alu_result_ip;
            SEL_LOAD: wb_value = load_value;
            SEL_PC4:  wb_value = pc_addr_ip + 32'd4;
            SEL_UIMM: wb_value = uimmd_ip;
            default:  ;
        endcase

        is_load      = valid_ip && (wb_sel_ip == SEL_LOAD);
        enter_wait   = (state == IDLE) && is_load && aligned && !load_valid_ip;
        misalign_now = (state == IDLE) && is_load && !aligned;
        wait_expired = (state == WAIT_LOAD) && !load_valid_ip && (wait_cnt == LAST_WAIT);
        complete_now = ((state == IDLE) && valid_ip && (!is_load || (aligned && load_valid_ip)))
                    || ((state == WAIT_LOAD) && load_valid_ip);

        // Released in the cycle the data arrives or the wait expires, so upstream advances then.
        stall_op = !reset && (enter_wait
                 || ((state == WAIT_LOAD) && !load_valid_ip && !wait_expired));
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rf_we_op    <= 1'b0;
            rf_waddr_op <= '0;
            rf_wdata_op <= '0;
            misalign_op <= 1'b0;
            timeout_op  <= 1'b0;
            retired_op  <= '0;
        end else begin
            rf_we_op    <= 1'b0;
            misalign_op <= misalign_now;
            timeout_op  <= wait_expired;

            // Address and data hold between completions so the last write stays forwardable.
            if (complete_now) begin
                rf_we_op    <= (rd_addr_ip != 5'd0);
                rf_waddr_op <= rd_addr_ip;
                rf_wdata_op <= wb_value;
                retired_op  <= retired_op + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (enter_wait) begin
                        state    <= WAIT_LOAD;
                        wait_cnt <= '0;
                    end
                end
                WAIT_LOAD: begin
                    if (load_valid_ip || wait_expired) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed scenarios with literal expectations, then a random
// stream; a transaction-level model predicts stall and the registered outputs every cycle.
module tb_write_back_stage;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             valid_ip;
    logic [1:0]       wb_sel_ip;
    logic [4:0]       rd_addr_ip;
    logic [31:0]      alu_result_ip;
    logic [31:0]      pc_addr_ip;
    logic [31:0]      uimmd_ip;
    logic [2:0]       lsu_op_ip;
    logic [1:0]       byte_off_ip;
    logic [31:0]      load_data_ip;
    logic             load_valid_ip;
    logic             stall_op;
    logic             rf_we_op;
    logic [4:0]       rf_waddr_op;
    logic [31:0]      rf_wdata_op;
    logic             misalign_op;
    logic             timeout_op;
    logic [CNT_W-1:0] retired_op;

    always #5 clock = ~clock;

    write_back_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .valid_ip(valid_ip), .wb_sel_ip(wb_sel_ip),
        .rd_addr_ip(rd_addr_ip), .alu_result_ip(alu_result_ip), .pc_addr_ip(pc_addr_ip),
        .uimmd_ip(uimmd_ip), .lsu_op_ip(lsu_op_ip), .byte_off_ip(byte_off_ip),
        .load_data_ip(load_data_ip), .load_valid_ip(load_valid_ip), .stall_op(stall_op),
        .rf_we_op(rf_we_op), .rf_waddr_op(rf_waddr_op), .rf_wdata_op(rf_wdata_op),
        .misalign_op(misalign_op), .timeout_op(timeout_op), .retired_op(retired_op)
    );

    int checks = 0;
    int errors = 0;

    // Model state: whether an accepted load is outstanding and how many stalled cycles it used.
    bit          m_pending;
    int          m_waited;
    bit          m_stall;
    bit          m_we;
    int unsigned m_waddr;
    int unsigned m_wdata;
    bit          m_mis;
    bit          m_to;
    int unsigned m_ret;
    bit          seen_stall;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int unsigned load_value(input int unsigned op, input int unsigned off,
                                               input int unsigned data);
        int unsigned b;
        int unsigned h;
        b = (data >> (off * 8)) % 256;
        h = (data >> ((off / 2) * 16)) % 65536;
        case (op)
            0:       return (b >= 128) ? (b + 32'hFFFFFF00) : b;
            4:       return b;
            1:       return (h >= 32768) ? (h + 32'hFFFF0000) : h;
            5:       return h;
            default: return data;
        endcase
    endfunction

    function automatic bit is_misaligned(input int unsigned op, input int unsigned off);
        if (op == 0 || op == 4) return 1'b0;
        if (op == 1 || op == 5) return (off % 2) == 1;
        return off != 0;
    endfunction

    function automatic int unsigned result_value();
        case (wb_sel_ip)
            2'd0:    return alu_result_ip;
            2'd1:    return load_value(lsu_op_ip, byte_off_ip, load_data_ip);
            2'd2:    return pc_addr_ip + 32'd4;
            default: return uimmd_ip;
        endcase
    endfunction

    task automatic model_complete();
        m_we    = (rd_addr_ip != 0);
        m_waddr = rd_addr_ip;
        m_wdata = result_value();
        m_ret   = (m_ret + 1) % (1 << CNT_W);
    endtask

    // Advance the model by one cycle using the inputs currently applied.
    task automatic model_cycle();
        m_we = 1'b0; m_mis = 1'b0; m_to = 1'b0; m_stall = 1'b0;
        if (reset) begin
            m_pending = 1'b0; m_waddr = 0; m_wdata = 0; m_ret = 0;
        end else if (m_pending) begin
            if (load_valid_ip) begin
                model_complete();
                m_pending = 1'b0;
            end else if (m_waited >= TIMEOUT) begin
                m_to      = 1'b1;
                m_pending = 1'b0;
            end else begin
                m_stall  = 1'b1;
                m_waited++;
            end
        end else if (valid_ip) begin
            if (wb_sel_ip != 2'd1) begin
                model_complete();
            end else if (is_misaligned(lsu_op_ip, byte_off_ip)) begin
                m_mis = 1'b1;
            end else if (load_valid_ip) begin
                model_complete();
            end else begin
                m_stall   = 1'b1;
                m_pending = 1'b1;
                m_waited  = 1;
            end
        end
    endtask

    // One clock: inputs already applied; compare stall mid-cycle, registered outputs after the edge.
    task automatic step();
        #1;
        model_cycle();
        seen_stall = stall_op;
        check("stall", 32'(stall_op), 32'(m_stall));
        @(posedge clock);
        #1;
        check("rf_we", 32'(rf_we_op), 32'(m_we));
        check("rf_waddr", 32'(rf_waddr_op), m_waddr);
        check("rf_wdata", rf_wdata_op, m_wdata);
        check("misalign", 32'(misalign_op), 32'(m_mis));
        check("timeout", 32'(timeout_op), 32'(m_to));
        check("retired", 32'(retired_op), m_ret);
    endtask

    task automatic set_insn(input logic v, input logic [1:0] sel, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] uimm,
                            input logic [2:0] op, input logic [1:0] off, input logic [31:0] data,
                            input logic lv);
        valid_ip = v; wb_sel_ip = sel; rd_addr_ip = rd; alu_result_ip = alu; pc_addr_ip = pc;
        uimmd_ip = uimm; lsu_op_ip = op; byte_off_ip = off; load_data_ip = data; load_valid_ip = lv;
    endtask

    int n;

    initial begin
        m_pending = 1'b0; m_waited = 0; m_ret = 0; m_waddr = 0; m_wdata = 0;
        reset = 1'b1;
        set_insn(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0);
        @(posedge clock);
        #1;
        step();
        step();
        check("reset_retired", 32'(retired_op), 32'd0);
        check("reset_wdata", rf_wdata_op, 32'd0);
        reset = 1'b0;

        // ALU result write
        set_insn(1'b1, 2'd0, 5'd5, 32'hDEADBEEF, 32'd0, 32'd0, 3'd2, 2'd0, 32'd0, 1'b0);
        step();
        check("t1_stall", 32'(seen_stall), 32'd0);
        check("t1_we", 32'(rf_we_op), 32'd1);
        check("t1_waddr", 32'(rf_waddr_op), 32'd5);
        check("t1_wdata", rf_wdata_op, 32'hDEADBEEF);
        check("t1_retired", 32'(retired_op), 32'd1);

        // Sub-word load extraction
        set_insn(1'b1, 2'd1, 5'd6, 32'd0, 32'd0, 32'd0, 3'd0, 2'd3, 32'h80FF0000, 1'b1);
        step();
        check("t2_lb", rf_wdata_op, 32'hFFFFFF80);
        lsu_op_ip = 3'd4;
        step();
        check("t2_lbu", rf_wdata_op, 32'h00000080);
        lsu_op_ip = 3'd5; byte_off_ip = 2'd2;
        step();
        check("t2_lhu", rf_wdata_op, 32'h000080FF);
        check("t2_retired", 32'(retired_op), 32'd4);

        // Late load: three cycles without data, then data
        set_insn(1'b1, 2'd1, 5'd7, 32'd0, 32'd0, 32'd0, 3'd2, 2'd0, 32'h12345678, 1'b0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (seen_stall) n++;
        end
        check("t3_we_while_stalled", 32'(rf_we_op), 32'd0);
        check("t3_stall_cycles", n, 32'd3);
        load_valid_ip = 1'b1;
        step();
        check("t3_stall_on_data", 32'(seen_stall), 32'd0);
        check("t3_we", 32'(rf_we_op), 32'd1);
        check("t3_wdata", rf_wdata_op, 32'h12345678);
        check("t3_retired", 32'(retired_op), 32'd5);

        // Abandoned load
        set_insn(1'b1, 2'd1, 5'd8, 32'd0, 32'd0, 32'd0, 3'd2, 2'd0, 32'hCAFEF00D, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!seen_stall) break;
            n++;
        end
        check("t4_stall_cycles", n, 32'd4);
        check("t4_timeout", 32'(timeout_op), 32'd1);
        check("t4_we", 32'(rf_we_op), 32'd0);
        check("t4_retired", 32'(retired_op), 32'd5);
        valid_ip = 1'b0;
        step();
        check("t4_pulse_end", 32'(timeout_op), 32'd0);

        // Misaligned word, PC+4 wrap, write to x0
        set_insn(1'b1, 2'd1, 5'd9, 32'd0, 32'd0, 32'd0, 3'd2, 2'd2, 32'h11111111, 1'b1);
        step();
        check("t5_misalign", 32'(misalign_op), 32'd1);
        check("t5_mis_we", 32'(rf_we_op), 32'd0);
        set_insn(1'b1, 2'd2, 5'd3, 32'd0, 32'hFFFFFFFC, 32'd0, 3'd2, 2'd0, 32'd0, 1'b0);
        step();
        check("t5_pc4", rf_wdata_op, 32'd0);
        check("t5_pc4_we", 32'(rf_we_op), 32'd1);
        set_insn(1'b1, 2'd3, 5'd0, 32'd0, 32'd0, 32'hABCDE000, 3'd2, 2'd0, 32'd0, 1'b0);
        step();
        check("t5_x0_we", 32'(rf_we_op), 32'd0);
        check("t5_x0_retired", 32'(retired_op), 32'd7);

        // Reset while waiting, then late data arrives
        set_insn(1'b1, 2'd1, 5'd10, 32'd0, 32'd0, 32'd0, 3'd2, 2'd0, 32'h55AA55AA, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; valid_ip = 1'b0; load_valid_ip = 1'b1;
        step();
        check("t6_we", 32'(rf_we_op), 32'd0);
        check("t6_wdata", rf_wdata_op, 32'd0);
        check("t6_retired", 32'(retired_op), 32'd0);
        check("t6_stall", 32'(seen_stall), 32'd0);
        check("t6_timeout", 32'(timeout_op), 32'd0);

        // Random stream; inputs are frozen while stall was high, except load_valid
        for (int c = 0; c < 3000; c++) begin
            if (!m_stall) begin
                valid_ip      = ($urandom_range(0, 9) < 8);
                wb_sel_ip     = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'($urandom);
                rd_addr_ip    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                alu_result_ip = $urandom;
                pc_addr_ip    = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
                uimmd_ip      = $urandom;
                lsu_op_ip     = 3'($urandom);
                byte_off_ip   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom);
                load_data_ip  = $urandom;
                load_valid_ip = ($urandom_range(0, 2) == 0);
            end else begin
                load_valid_ip = ($urandom_range(0, 3) == 0);
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
